// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : time_set_controller
// Description : 1 Hz tick generation with seconds->minutes->hours ripple and
//               the RUN / SET_HOURS / SET_MINUTES time-setting state machine.
//               Optional INC auto-repeat: define TIME_SET_AUTO_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_controller #(
    parameter int c_CLOCKS_PER_SECOND = 50_000_000,
    parameter int c_REPEAT_DELAY      = 25_000_000,
    parameter int c_REPEAT_PERIOD     = 10_000_000
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Mode_Press,
    input  logic       i_Inc_Press,
    input  logic       i_Inc_Hold,
    input  logic       i_Seconds_Max,
    input  logic       i_Minutes_Max,
    output logic       o_Seconds_Enable,
    output logic       o_Minutes_Enable,
    output logic       o_Hours_Enable,
    output logic       o_Seconds_Clear,
    output logic [1:0] o_Mode,
    output logic       o_Blink
);

    localparam int c_PRESCALE_W = $clog2(c_CLOCKS_PER_SECOND);
    localparam logic [c_PRESCALE_W-1:0] c_LAST = c_PRESCALE_W'(c_CLOCKS_PER_SECOND - 1);
    localparam logic [c_PRESCALE_W-1:0] c_HALF = c_PRESCALE_W'(c_CLOCKS_PER_SECOND / 2);

    typedef enum logic [1:0] {
        RUN         = 2'b00,
        SET_HOURS   = 2'b01,
        SET_MINUTES = 2'b10
    } state_t;

    if ((c_CLOCKS_PER_SECOND < 4) || ((c_CLOCKS_PER_SECOND % 2) != 0)
        || (c_REPEAT_DELAY < 1) || (c_REPEAT_PERIOD < 1)) begin : g_param_check
        $error("time_set_controller: invalid parameter set");
    end

    state_t                  r_state_q, w_state_d;
    logic [c_PRESCALE_W-1:0] r_count_q, w_count_d;
    logic                    r_sec_en_q, w_sec_en_d;
    logic                    r_min_en_q, w_min_en_d;
    logic                    r_hr_en_q, w_hr_en_d;
    logic                    r_clear_q, w_clear_d;
    logic                    r_blink_q, w_blink_d;
    logic                    w_wrap;
    logic                    w_inc;
    logic                    w_repeat;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int c_DELAY_W  = $clog2(c_REPEAT_DELAY + 1);
    localparam int c_PERIOD_W = $clog2(c_REPEAT_PERIOD + 1);
    localparam logic [c_DELAY_W-1:0]  c_DELAY_MAX  = c_DELAY_W'(c_REPEAT_DELAY);
    localparam logic [c_PERIOD_W-1:0] c_PERIOD_MAX = c_PERIOD_W'(c_REPEAT_PERIOD - 1);

    logic [c_DELAY_W-1:0]  r_hold_q, w_hold_d;
    logic [c_PERIOD_W-1:0] r_period_q, w_period_d;

    // Hold counter saturates at the delay, then the period counter paces repeats.
    always_comb begin
        w_hold_d   = r_hold_q;
        w_period_d = r_period_q;
        w_repeat   = 1'b0;
        if (!i_Inc_Hold || i_Mode_Press || (r_state_q == RUN)) begin
            w_hold_d   = '0;
            w_period_d = '0;
        end else if (r_hold_q != c_DELAY_MAX) begin
            w_hold_d = r_hold_q + 1'b1;
            w_repeat = (w_hold_d == c_DELAY_MAX);
        end else if (r_period_q == c_PERIOD_MAX) begin
            w_period_d = '0;
            w_repeat   = 1'b1;
        end else begin
            w_period_d = r_period_q + 1'b1;
        end
    end
`else
    logic w_unused_hold;
    assign w_unused_hold = i_Inc_Hold;
    assign w_repeat      = 1'b0;
`endif

    assign w_wrap = (r_count_q == c_LAST);
    assign w_inc  = i_Inc_Press | w_repeat;

    always_comb begin
        w_state_d  = r_state_q;
        w_count_d  = w_wrap ? '0 : r_count_q + 1'b1;
        w_sec_en_d = 1'b0;
        w_min_en_d = 1'b0;
        w_hr_en_d  = 1'b0;
        w_clear_d  = 1'b0;
        if (i_Mode_Press) begin
            // Every transition restarts the prescaler, so blink and ticks realign.
            w_count_d = '0;
            case (r_state_q)
                RUN: begin
                    w_state_d = SET_HOURS;
                    w_clear_d = 1'b1;
                end
                SET_HOURS: w_state_d = SET_MINUTES;
                default:   w_state_d = RUN;
            endcase
        end else begin
            case (r_state_q)
                RUN: begin
                    w_sec_en_d = w_wrap;
                    w_min_en_d = w_wrap & i_Seconds_Max;
                    w_hr_en_d  = w_wrap & i_Seconds_Max & i_Minutes_Max;
                end
                SET_HOURS:   w_hr_en_d  = w_inc;
                SET_MINUTES: w_min_en_d = w_inc;
                default:     w_state_d  = RUN;
            endcase
        end
        w_blink_d = (w_state_d == RUN) || (w_count_d < c_HALF);
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state_q  <= RUN;
            r_count_q  <= '0;
            r_sec_en_q <= 1'b0;
            r_min_en_q <= 1'b0;
            r_hr_en_q  <= 1'b0;
            r_clear_q  <= 1'b0;
            r_blink_q  <= 1'b1;
`ifdef TIME_SET_AUTO_REPEAT_EN
            r_hold_q   <= '0;
            r_period_q <= '0;
`endif
        end else begin
            r_state_q  <= w_state_d;
            r_count_q  <= w_count_d;
            r_sec_en_q <= w_sec_en_d;
            r_min_en_q <= w_min_en_d;
            r_hr_en_q  <= w_hr_en_d;
            r_clear_q  <= w_clear_d;
            r_blink_q  <= w_blink_d;
`ifdef TIME_SET_AUTO_REPEAT_EN
            r_hold_q   <= w_hold_d;
            r_period_q <= w_period_d;
`endif
        end
    end

    assign o_Seconds_Enable = r_sec_en_q;
    assign o_Minutes_Enable = r_min_en_q;
    assign o_Hours_Enable   = r_hr_en_q;
    assign o_Seconds_Clear  = r_clear_q;
    assign o_Mode           = r_state_q;
    assign o_Blink          = r_blink_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_controller
// Description : Randomized self-checking bench with a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_controller;

    localparam int N = 10;
    localparam int D = 4;
    localparam int P = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       mp    = 1'b0;
    logic       ip    = 1'b0;
    logic       ih    = 1'b0;
    logic       smax  = 1'b0;
    logic       mmax  = 1'b0;
    logic       sec_en, min_en, hr_en, sec_clr, blink;
    logic [1:0] mode;
    logic [6:0] obs;
    logic [6:0] exp_v;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int m_mode, m_phase, m_hold;

    time_set_controller #(
        .c_CLOCKS_PER_SECOND(N),
        .c_REPEAT_DELAY     (D),
        .c_REPEAT_PERIOD    (P)
    ) dut (
        .i_Clock         (clk),
        .i_Reset_n       (rst_n),
        .i_Mode_Press    (mp),
        .i_Inc_Press     (ip),
        .i_Inc_Hold      (ih),
        .i_Seconds_Max   (smax),
        .i_Minutes_Max   (mmax),
        .o_Seconds_Enable(sec_en),
        .o_Minutes_Enable(min_en),
        .o_Hours_Enable  (hr_en),
        .o_Seconds_Clear (sec_clr),
        .o_Mode          (mode),
        .o_Blink         (blink)
    );

    always #5 clk = ~clk;

    assign obs = {mode, blink, sec_clr, hr_en, min_en, sec_en};

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, got=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_hold  = 0;
        exp_v   = 7'b00_1_0000;
    endtask

    // Advance one clock edge and compute expected outputs from the behavioural rules.
    task automatic step();
        logic s, mn, h, c, inc, rep;
        s = 1'b0; mn = 1'b0; h = 1'b0; c = 1'b0; inc = 1'b0; rep = 1'b0;
        @(posedge clk);
        if (mp) begin
            c       = (m_mode == 0);
            m_mode  = (m_mode + 1) % 3;
            m_phase = 0;
            m_hold  = 0;
        end else begin
            if (m_mode == 0) begin
                s      = (m_phase == N - 1);
                mn     = s & smax;
                h      = s & smax & mmax;
                m_hold = 0;
            end else begin
`ifdef TIME_SET_AUTO_REPEAT_EN
                if (ih) begin
                    m_hold = m_hold + 1;
                    rep    = (m_hold == D) || ((m_hold > D) && ((m_hold - D) % P == 0));
                end else begin
                    m_hold = 0;
                end
`endif
                inc = ip | rep;
                if (m_mode == 1) h = inc;
                else             mn = inc;
            end
            m_phase = (m_phase + 1) % N;
        end
        exp_v = {2'(m_mode), (m_mode == 0) || (m_phase < N / 2), c, h, mn, s};
        cyc++;
        #1;
    endtask

    task automatic drive(input logic m, input logic i, input logic h, input logic s, input logic mx);
        mp = m; ip = i; ih = h; smax = s; mmax = mx;
        step();
    endtask

    task automatic goto_mode(input int target);
        while (m_mode != target) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL goto_mode cyc=%0d got=%b required=%b", cyc, obs, exp_v);
            end
        end
        mp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mp = 0; ip = 0; ih = 0; smax = 0; mmax = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 7'b00_1_0000) begin
            errors++;
            $display("FAIL reset_state got=%b required=%b", obs, 7'b00_1_0000);
        end
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_run_tick();
        int n_sec = 0;
        for (int k = 1; k <= 30; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (sec_en) n_sec++;
            checks++;
            if (obs !== exp_v || sec_en !== (k % N == 0)) begin
                errors++;
                $display("FAIL run_tick k=%0d got=%b required=%b", k, obs, exp_v);
            end
        end
        checks++;
        if (n_sec != 3) begin
            errors++;
            $display("FAIL run_tick_count got=%0d required=3", n_sec);
        end
    endtask

    task automatic test_ripple();
        logic s, mx;
        for (int k = 0; k < 40; k++) begin
            if (k < 10)      begin s = 1'b1; mx = 1'b1; end
            else if (k < 20) begin s = 1'b1; mx = 1'b0; end
            else begin
                s  = 1'($urandom_range(0, 1));
                mx = 1'($urandom_range(0, 1));
            end
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, s, mx);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL ripple cyc=%0d got=%b required=%b", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_mode_cycle();
        int n_clr = 0;
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (sec_clr) n_clr++;
            checks++;
            if (obs !== exp_v || mode !== 2'((p + 1) % 3)) begin
                errors++;
                $display("FAIL mode_step p=%0d got=%b required=%b", p, obs, exp_v);
            end
            for (int g = 0; g < int'($urandom_range(1, 5)); g++) begin
                drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if (sec_clr) n_clr++;
                if (p == 2 && sec_en) begin
                    errors++;
                    $display("FAIL early_tick cyc=%0d got=1 required=0", cyc);
                end
            end
        end
        for (int k = 0; k < 12; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (sec_clr) n_clr++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL return_run cyc=%0d got=%b required=%b", cyc, obs, exp_v);
            end
        end
        checks++;
        if (n_clr != 1) begin
            errors++;
            $display("FAIL clear_count got=%0d required=1", n_clr);
        end
    endtask

    task automatic test_set_increments();
        int n_hr = 0;
        goto_mode(1);
        for (int p = 0; p < 3; p++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (hr_en) n_hr++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL hours_inc cyc=%0d got=%b required=%b", cyc, obs, exp_v);
            end
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
                if (hr_en) n_hr++;
            end
        end
        checks++;
        if (n_hr != 3) begin
            errors++;
            $display("FAIL hours_count got=%0d required=3", n_hr);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (obs !== exp_v || hr_en !== 1'b0 || mode !== 2'b10) begin
            errors++;
            $display("FAIL mode_beats_inc got=%b required=%b", obs, exp_v);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'(k % 2 == 0), 1'b0, 1'b1, 1'b1);
            checks++;
            if (obs !== exp_v || hr_en !== 1'b0) begin
                errors++;
                $display("FAIL minutes_inc cyc=%0d got=%b required=%b", cyc, obs, exp_v);
            end
        end
    endtask

    task automatic test_auto_repeat();
        int n_min = 0;
        int want;
`ifdef TIME_SET_AUTO_REPEAT_EN
        want = 6;
`else
        want = 1;
`endif
        goto_mode(2);
        for (int k = 1; k <= 15; k++) begin
            drive(1'b0, 1'(k == 1), 1'(k <= 12), 1'b0, 1'b1);
            if (min_en) n_min++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL auto_repeat k=%0d got=%b required=%b", k, obs, exp_v);
            end
        end
        checks++;
        if (n_min != want) begin
            errors++;
            $display("FAIL repeat_count got=%0d required=%0d", n_min, want);
        end
    endtask

    task automatic test_blink();
        goto_mode(1);
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v || blink !== ((k % N) < N / 2)) begin
                errors++;
                $display("FAIL blink k=%0d got=%b required=%b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        goto_mode(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 7'b00_1_0000) begin
            errors++;
            $display("FAIL reset_mid got=%b required=%b", obs, 7'b00_1_0000);
        end
        ip = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        logic prev_ip = 1'b0;
        logic nip;
        for (int k = 0; k < 300; k++) begin
            nip = !prev_ip && ($urandom_range(0, 2) == 0);
            drive(1'($urandom_range(0, 11) == 0), nip, 1'b0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            prev_ip = nip;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b required=%b", cyc, obs, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_run_tick();
        test_ripple();
        test_mode_cycle();
        test_set_increments();
        test_auto_repeat();
        test_blink();
        test_reset_mid();
        test_run_tick();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
